// File: rtl/mult_unit_if.sv
// Request/response bundle for mult_unit: operands and start from the requester,
// busy/done and the hi/lo product halves back from the multiplier.
interface mult_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, is_signed, a, b, input busy, done, hi, lo);
  modport slave  (input start, is_signed, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mult_unit.sv
// Radix-2 shift-add multiplier (MIPS mult/multu), one partial product per clock.
// Define MULT_UNIT_SIGNED_EN to enable signed operation via magnitude/negate.
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  mult_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] product;

  // The carry-out lands in sum[WIDTH] and is shifted into the accumulator MSB.
  assign sum = {1'b0, acc} + {1'b0, (mplier[0] ? mcand : '0)};

`ifdef MULT_UNIT_SIGNED_EN
  logic neg;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? -x : x;
  endfunction

  assign product = neg ? -{acc, mplier} : {acc, mplier};
`else
  logic unused_is_signed;
  assign unused_is_signed = bus.is_signed;
  assign product = {acc, mplier};
`endif

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears the datapath registers too, so an
    // aborted operation leaves no partial product behind.
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef MULT_UNIT_SIGNED_EN
      neg    <= 1'b0;
`endif
    end else begin
      // NOTE: every state register uses <= so all updates see pre-edge values.
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
`ifdef MULT_UNIT_SIGNED_EN
            mcand  <= magnitude(bus.a, bus.is_signed);
            mplier <= magnitude(bus.b, bus.is_signed);
            neg    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
`else
            mcand  <= bus.a;
            mplier <= bus.b;
`endif
            acc    <= '0;
            cnt    <= CW'(WIDTH);
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= sum[WIDTH:1];
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DONE;
        end
        DONE: begin
          hi_q   <= product[2*WIDTH-1:WIDTH];
          lo_q   <= product[WIDTH-1:0];
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_unit.sv
// Scoreboard bench for mult_unit: drivers push expected products, a monitor
// pops and compares on every done pulse, including done-cycle timing.
module tb_mult_unit;
  localparam int W = 32;
`ifdef MULT_UNIT_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  mult_unit_if #(.WIDTH(W)) bus ();
  mult_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] prod;
    int             due;
  } exp_t;

  exp_t           sb[$];
  int             n_checks  = 0;
  int             n_fail    = 0;
  int             cyc       = 0;
  int             done_seen = 0;
  logic [2*W-1:0] last_res  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: sign-extend when signed mode applies, multiply at 2W bits.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    logic [2*W-1:0] ea, eb;
    if (s && SIGNED_EN) begin
      ea = {{W{a[W-1]}}, a};
      eb = {{W{b[W-1]}}, b};
    end else begin
      ea = {{W{1'b0}}, a};
      eb = {{W{1'b0}}, b};
    end
    return ea * eb;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every done must match the oldest expectation, and busy must be low next cycle.
  initial begin
    exp_t e;
    bit   busy_chk;
    busy_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_chk) begin
        check("busy_after_done", 64'(bus.busy), 64'd0);
        busy_chk = 1'b0;
      end
      if (bus.done === 1'b1) begin
        done_seen++;
        busy_chk = 1'b1;
        if (sb.size() == 0) begin
          check("unexpected_done", {bus.hi, bus.lo}, last_res);
          n_fail++;
          $display("FAIL unexpected_done: got done pulse, required none (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("product", {bus.hi, bus.lo}, e.prod);
          check("latency", 64'(cyc), 64'(e.due));
          last_res = e.prod;
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [2*W-1:0] exp);
    exp_t e;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.is_signed = s;
    e.prod = exp;
    e.due  = cyc + W + 2;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 4 * W && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [2*W-1:0] exp);
    issue(a, b, s, exp);
    repeat (16) @(negedge clk);
    check("busy_in_run", 64'(bus.busy), 64'd1);
    check("hold_during_run", {bus.hi, bus.lo}, last_res);
    wait_drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int d0;
    logic [W-1:0] ra, rb;
    logic         rs;

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    reset = 1'b0;

    run_op(32'h0000_0007, 32'h0000_0006, 1'b0, 64'h0000_0000_0000_002A);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    run_op(32'h0000_0000, 32'h1234_5678, 1'b0, 64'h0);
    run_op(32'hFFFF_FFFD, 32'h0000_0005, 1'b1,
           SIGNED_EN ? 64'hFFFF_FFFF_FFFF_FFF1 : 64'h0000_0004_FFFF_FFF1);
    run_op(32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 64'h0000_0004_FFFF_FFF1);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);

    // Busy protection: second start mid-operation must be ignored.
    d0 = done_seen;
    issue(32'd2, 32'd3, 1'b0, 64'd6);
    repeat (8) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();
    repeat (W) @(negedge clk);
    check("single_done", 64'(done_seen - d0), 64'd1);

    // Reset mid-RUN aborts without a done pulse and clears the result.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd5;
    bus.b     = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (13) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    d0 = done_seen;
    repeat (2 * W) @(negedge clk);
    check("abort_no_done", 64'(done_seen - d0), 64'd0);
    check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    last_res = '0;
    run_op(32'd4, 32'd4, 1'b0, 64'h10);

    // Start and reset together: reset wins.
    @(negedge clk);
    bus.start = 1'b1;
    reset     = 1'b1;
    bus.a     = 32'd11;
    bus.b     = 32'd13;
    @(negedge clk);
    bus.start = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    check("reset_wins_busy", 64'(bus.busy), 64'd0);
    check("reset_wins_hilo", {bus.hi, bus.lo}, 64'd0);
    last_res = '0;

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i % 7 == 3) ra = 32'h8000_0000;
      if (i % 9 == 4) rb = 32'hFFFF_FFFF;
      run_op(ra, rb, rs, model(ra, rb, rs));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
